// File: rtl/qual_pkg.sv
// Shared types and constants for the qual_v2 trigger qualifier.
//   state_t        : qualifier FSM states
//   QUAL_MODE_*    : combine-mode encodings for the 2-bit mode input
//                    (encoding 3 behaves as QUAL_MODE_EDGE)
package qual_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_TRIGGER,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_HOLDOFF,
    ST_DONE
  } state_t;

  localparam logic [1:0] QUAL_MODE_OR   = 2'd0;
  localparam logic [1:0] QUAL_MODE_AND  = 2'd1;
  localparam logic [1:0] QUAL_MODE_EDGE = 2'd2;

endpackage

// File: rtl/qual_v2_if.sv
// Write handshake between the trigger qualifier and the memory writer.
//   write     : write request (qualifier -> writer)
//   write_ack : acknowledge   (writer -> qualifier), four-phase
//   trig_vec  : masked channels that caused the current/last write
// Modports: master = qualifier side, slave = memory writer side.
interface qual_v2_if #(
  parameter int unsigned L = 4
);

  logic         write;
  logic         write_ack;
  logic [L-1:0] trig_vec;

  modport master (output write, output trig_vec, input write_ack);
  modport slave  (input write, input trig_vec, output write_ack);

endinterface

// File: rtl/qual_trig.sv
// Trigger combine logic: registers the previous din sample and qualifies
// din against the latched mask in the latched combine mode.
//   aclk, aresetn : clock, synchronous active-low reset
//   din           : raw trigger inputs
//   mask_r        : latched channel mask
//   mode_r        : latched combine mode (qual_pkg::QUAL_MODE_*)
//   trig          : trigger condition this cycle (combinational)
//   hit           : channels that satisfy the condition (rising bits in edge mode)
module qual_trig
  import qual_pkg::*;
#(
  parameter int unsigned L = 4
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [L-1:0] din,
  input  logic [L-1:0] mask_r,
  input  logic [1:0]   mode_r,
  output logic         trig,
  output logic [L-1:0] hit
);

  logic [L-1:0] din_q;
  logic [L-1:0] m;
  logic [L-1:0] rise;

  // Sampled every cycle regardless of FSM state, so an input already high
  // at arm time is never seen as a rising edge.
  always_ff @(posedge aclk) begin
    if (!aresetn) din_q <= '0;
    else          din_q <= din;
  end

  always_comb begin
    m    = din & mask_r;
    rise = din & ~din_q & mask_r;
    trig = 1'b0;
    hit  = m;
    case (mode_r)
      QUAL_MODE_OR:  trig = |m;
      QUAL_MODE_AND: trig = (mask_r != '0) && (m == mask_r);
      default: begin
        trig = |rise;
        hit  = rise;
      end
    endcase
  end

endmodule

// File: rtl/qual_v2.sv
// Trigger qualifier for the capture buffer path. Qualifies L trigger inputs,
// runs a four-phase write/write_ack handshake per qualified trigger, and
// applies a programmable holdoff and write-count limit.
// Optional feature macro: QUAL_ACK_TIMEOUT_EN (ack timeout after TOUT cycles
// in WRITE, sets sticky err and ends in DONE).
//   aclk, aresetn : clock, synchronous active-low reset
//   start         : level arm/abort
//   mask, mode    : channel mask and combine mode, latched at arm
//   holdoff, nmax : idle cycles after each write / write limit (0 = none)
//   din           : trigger inputs
//   bus           : write handshake (write, write_ack, trig_vec)
//   nwrites       : completed writes since arm
//   busy, done    : state decodes
//   err           : sticky ack-timeout flag (0 without the macro)
module qual_v2
  import qual_pkg::*;
#(
  parameter int unsigned L    = 4,
  parameter int unsigned NCNT = 16,
  parameter int unsigned TOUT = 1024
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            start,
  input  logic [L-1:0]    mask,
  input  logic [1:0]      mode,
  input  logic [NCNT-1:0] holdoff,
  input  logic [NCNT-1:0] nmax,
  input  logic [L-1:0]    din,
  qual_v2_if.master       bus,
  output logic [NCNT-1:0] nwrites,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_t          state, next;
  logic [L-1:0]    mask_r;
  logic [1:0]      mode_r;
  logic [NCNT-1:0] holdoff_r;
  logic [NCNT-1:0] nmax_r;
  logic [NCNT-1:0] hcnt;
  logic [L-1:0]    trig_vec_r;
  logic            trig;
  logic [L-1:0]    hit;
  logic            tout_hit;

  qual_trig #(.L(L)) u_trig (
    .aclk   (aclk),
    .aresetn(aresetn),
    .din    (din),
    .mask_r (mask_r),
    .mode_r (mode_r),
    .trig   (trig),
    .hit    (hit)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= ST_INIT;
    else          state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      ST_INIT:    if (start) next = ST_TRIGGER;
      ST_TRIGGER: begin
        if (!start)    next = ST_INIT;
        else if (trig) next = ST_WRITE;
      end
      ST_WRITE: begin
        if (bus.write_ack) next = ST_WRITE_ACK;
        else if (tout_hit) next = ST_DONE;
      end
      ST_WRITE_ACK: begin
        // nwrites already includes the write that was just acknowledged
        if (!bus.write_ack) begin
          if (nmax_r != '0 && nwrites == nmax_r) next = ST_DONE;
          else if (holdoff_r != '0)              next = ST_HOLDOFF;
          else                                   next = ST_TRIGGER;
        end
      end
      ST_HOLDOFF: begin
        if (!start)                 next = ST_INIT;
        else if (hcnt == holdoff_r) next = ST_TRIGGER;
      end
      ST_DONE:    if (!start) next = ST_INIT;
      default:    next = ST_INIT;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      mask_r     <= '0;
      mode_r     <= '0;
      holdoff_r  <= '0;
      nmax_r     <= '0;
      nwrites    <= '0;
      trig_vec_r <= '0;
      hcnt       <= '0;
    end else begin
      if (state == ST_INIT && start) begin
        mask_r    <= mask;
        mode_r    <= mode;
        holdoff_r <= holdoff;
        nmax_r    <= nmax;
        nwrites   <= '0;
      end
      if (state == ST_TRIGGER && next == ST_WRITE) trig_vec_r <= hit;
      if (state == ST_WRITE && bus.write_ack) nwrites <= nwrites + NCNT'(1);
      // Counts 1..holdoff_r while in HOLDOFF; exit when it equals holdoff_r
      hcnt <= (state == ST_HOLDOFF) ? hcnt + NCNT'(1) : NCNT'(1);
    end
  end

  assign bus.write    = (state == ST_WRITE);
  assign bus.trig_vec = trig_vec_r;
  assign busy = (state inside {ST_TRIGGER, ST_WRITE, ST_WRITE_ACK, ST_HOLDOFF});
  assign done = (state == ST_DONE);

`ifdef QUAL_ACK_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TOUT + 1);
  logic [TW-1:0] tcnt;
  logic          err_r;

  // tcnt counts WRITE cycles already completed without an ack
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tcnt  <= '0;
      err_r <= 1'b0;
    end else begin
      tcnt <= (state == ST_WRITE) ? tcnt + TW'(1) : '0;
      if (state == ST_INIT && start) err_r <= 1'b0;
      else if (tout_hit)             err_r <= 1'b1;
    end
  end

  assign tout_hit = (state == ST_WRITE) && !bus.write_ack && (tcnt == TW'(TOUT - 1));
  assign err      = err_r;
`else
  logic unused_tout;
  assign unused_tout = |TOUT;
  assign tout_hit    = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: doc/qual_v2.md
# qual_v2

Parametrised trigger qualifier for the capture buffer path. It watches `L` trigger inputs and qualifies them with a channel mask and a selectable combine mode (OR-level, AND-level, OR-rising-edge). On each qualified trigger it runs a four-phase `write`/`write_ack` handshake with the memory writer and reports which channels fired. It adds a programmable holdoff between writes and a write-count limit, and sits between the trigger sources and the memory writer.

## Interface
- `L`, 4, number of trigger inputs.
- `NCNT`, 16, width of the holdoff, limit and write counters.
- `TOUT`, 1024, ack timeout in cycles; only used with `QUAL_ACK_TIMEOUT_EN`.

- `aclk`  in  1  clock.
- `aresetn`  in  1  reset; synchronous, active-low.
- `start`  in  1  level enable; high arms the block, low aborts or returns to idle.
- `mask`  in  L  channel enable; latched at arm.
- `mode`  in  2  0 = OR level, 1 = AND level, 2 = OR rising edge, 3 = same as 2; latched at arm.
- `holdoff`  in  NCNT  idle cycles after each write; 0 = none; latched at arm.
- `nmax`  in  NCNT  writes before DONE; 0 = unlimited; latched at arm.
- `din`  in  L  trigger inputs, synchronous to `aclk`.
- `write`  out  1  write request to the memory writer.
- `write_ack`  in  1  memory writer acknowledge.
- `trig_vec`  out  L  masked channels that caused the current or last write.
- `nwrites`  out  NCNT  completed writes since arm.
- `busy`  out  1  high in TRIGGER, WRITE, WRITE_ACK and HOLDOFF.
- `done`  out  1  high in DONE.
- `err`  out  1  sticky ack-timeout flag; tied 0 without the macro.

## Operation
- **States:** INIT, TRIGGER, WRITE, WRITE_ACK, HOLDOFF, DONE.
- **INIT:**
  - `start`=1 moves to TRIGGER.
  - On that same transition: latch `mask`/`mode`/`holdoff`/`nmax`, clear `nwrites` and `err`.
- **Trigger condition:** `m = din & mask_r`.
  - OR: `|m`.
  - AND: `mask_r != 0 && m == mask_r`.
  - Edge: `|(din & ~din_q & mask_r)`.
  - `din_q` is registered every cycle in every state and resets to 0.
  - `mask_r` = 0 never triggers.
- **TRIGGER:**
  - `start`=0 goes to INIT; this has priority over the trigger.
  - Otherwise, a trigger goes to WRITE and loads `trig_vec` with `m` (edge mode: the rising bits).
- **WRITE:**
  - `write`=1.
  - `write_ack`=1 goes to WRITE_ACK and increments `nwrites`, which wraps modulo 2^NCNT.
  - `start` is ignored; the handshake always completes.
- **WRITE_ACK:** on `write_ack`=0, the first matching rule applies:
  - `nmax != 0 && nwrites == nmax` goes to DONE.
  - else `holdoff_r != 0` goes to HOLDOFF.
  - else back to TRIGGER.
- **HOLDOFF:**
  - Stays exactly `holdoff_r` cycles, then goes to TRIGGER.
  - `start`=0 goes to INIT immediately.
  - Triggers arriving during holdoff are discarded, not queued.
- **DONE:** holds until `start`=0, then goes to INIT.
- **Retained values:** `nwrites` and `trig_vec` hold their values in INIT/DONE for readback.
- **Reset:**
  - State INIT.
  - `write`, `busy`, `done`, `err` = 0.
  - `trig_vec` = 0, `nwrites` = 0, `din_q` = 0.
  - Reset mid-handshake drops `write` the next cycle.

## Timing
- Every output is registered or decoded directly from the state register; no combinational path from `din`/`write_ack` to outputs.
- Trigger latency: `din` sampled at edge k (TRIGGER) gives `write`=1 from edge k+1.
- `write` falls the cycle after `write_ack`=1 is sampled.
- Minimum spacing between write rising edges, with immediate ack/release: 3 + `holdoff` cycles.
- Edge mode: an input already high when armed does not fire.
- Changing configuration inputs while armed has no effect until re-arm.

## Configuration
- `QUAL_ACK_TIMEOUT_EN` defined:
  - A counter runs in WRITE.
  - After `TOUT` cycles without `write_ack`, drop `write`, set `err`=1 and go to DONE.
  - `err` clears only on the next arm.
- Undefined:
  - WRITE waits indefinitely.
  - `err` is constant 0 and the counter is not built.

## Structure
- Package `qual_pkg`:
  - `state_t` enum.
  - Mode constants `QUAL_MODE_OR`, `QUAL_MODE_AND`, `QUAL_MODE_EDGE`.
- Sub-module `qual_trig`:
  - Contents: `din_q` register plus the mask/mode combine logic.
  - Outputs: `trig` and the hit vector.
- The FSM, counters and handshake stay in `qual_v2`.

## Test plan
- OR mode, `mask`=4'b0101, `din`=4'b0010 then 4'b0100 → no write, then `write`=1 one cycle later, `trig_vec`=4'b0100, `nwrites`=1 after ack.
- AND mode, `mask`=4'b0011 → `din`=4'b0001 gives no write; `din`=4'b0111 gives a write with `trig_vec`=4'b0011.
- Edge mode, `din[0]` held high across arm, then pulsed 0→1 → exactly one write, on the new edge only.
- `holdoff`=5, `din` constantly qualifying, immediate ack → write rising edges 8 cycles apart; triggers during holdoff are discarded.
- `nmax`=3 → `done`=1 after the 3rd ack release; `start` low then high re-arms with `nwrites`=0.
- `start` dropped in WRITE → handshake completes, then INIT.
- With the macro: `write_ack` never asserted → after `TOUT` cycles `write`=0, `err`=1, `done`=1.
